// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO and send controller feeding a UART transmitter.
// The host writes bytes at clock rate. The controller pops one byte, holds it on
// tx_data and raises tx_send. It then follows the transmitter's synchronized
// active/done flags, so frames go out back to back without host polling.
//
// Handshake: the host side has no backpressure. A write is accepted when
// wr_en && !full. A write while full is dropped and sets the sticky overflow flag.
// On the transmitter side, tx_send is a level request. It stays high until the
// synchronized active flag is seen. It then stays low through the frame and for
// at least one cycle before the next request.
module uart_tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_ovf,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     busy,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_send,
  input  logic                     tx_active,
  input  logic                     tx_done,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                act_m, act_s, done_m, done_s;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count_d;
  logic                wr_ok, pop;
  logic                send_d;
  logic [DATA_W-1:0]   data_d;

  assign wr_ok     = wr_en && !full;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  // Two-flop synchronizers for the baud-domain status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_m  <= 1'b0;
      act_s  <= 1'b0;
      done_m <= 1'b0;
      done_s <= 1'b0;
    end else begin
      act_m  <= tx_active;
      act_s  <= act_m;
      done_m <= tx_done;
      done_s <= done_m;
    end
  end

  // Next occupancy: a write and a pop in the same cycle cancel out
  always_comb begin
    count_d = count;
    case ({wr_ok, pop})
      2'b10:   count_d = count + 1'b1;
      2'b01:   count_d = count - 1'b1;
      default: count_d = count;
    endcase
  end

  // FIFO pointers and registered occupancy flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  // Storage array; it needs no reset because occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Sticky overflow; a dropped write wins over a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                overflow <= 1'b0;
    else if (wr_en && full)    overflow <= 1'b1;
    else if (clr_ovf)          overflow <= 1'b0;
  end

  // Send controller next state: pop in IDLE, hold request until active is seen
  always_comb begin
    state_d = state_q;
    send_d  = tx_send;
    data_d  = tx_data;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !act_s) begin
          pop     = 1'b1;
          data_d  = mem[rd_ptr];
          send_d  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (act_s) begin
          send_d  = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!act_s || done_s) state_d = S_GAP;
      end
      S_GAP: begin
        send_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Send controller registers; tx_data only changes on a pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tx_send <= 1'b0;
      tx_data <= '0;
    end else begin
      state_q <= state_d;
      tx_send <= send_d;
      tx_data <= data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder with a behavioural transmitter model.
module tb_uart_tx_feeder;

  localparam int DEPTH  = 16;
  localparam int W      = 8;
  localparam int BD     = 4;         // clocks per bit in the transmitter model
  localparam int FRAME  = 10 * BD;   // start + 8 data + stop

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         clr_ovf = 1'b0;
  logic         full, empty, overflow, busy, tx_send;
  logic [4:0]   count;
  logic [W-1:0] tx_data;
  logic         tx_active, tx_done;
  logic [1:0]   dbg_state;
  logic         hold = 1'b0;

  uart_tx_feeder #(.DEPTH(DEPTH), .DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .busy(busy),
    .tx_data(tx_data), .tx_send(tx_send), .tx_active(tx_active), .tx_done(tx_done),
    .dbg_state(dbg_state)
  );

  // Transmitter model: accepts a level send when idle, stays active for one
  // frame, then pulses done. The hold input forces active high with no frame.
  logic         m_active = 1'b0;
  logic         m_done = 1'b0;
  int           m_cnt = 0;
  int           m_dcnt = 0;
  logic [W-1:0] m_byte = '0;
  logic         send_low = 1'b1;
  int           stable_err = 0;
  int           overlap_err = 0;
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];

  assign tx_active = hold | m_active;
  assign tx_done   = m_done;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_cnt    = 0;
      send_low = 1'b1;
    end else begin
      if (!tx_send) send_low = 1'b1;
      if (m_active) begin
        if (tx_data !== m_byte) stable_err++;
        m_cnt--;
        if (m_cnt == 0) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_dcnt   = BD;
        end
      end else begin
        if (m_done) begin
          m_dcnt--;
          if (m_dcnt == 0) m_done = 1'b0;
        end
        if (tx_send && !hold) begin
          if (!send_low) overlap_err++;
          m_active = 1'b1;
          m_done   = 1'b0;
          m_byte   = tx_data;
          m_cnt    = FRAME;
          send_low = 1'b0;
          got_q.push_back(tx_data);
        end
      end
    end
  end

  // Scoreboard counters
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks (called on a falling edge, return on a falling edge)
  task automatic write_byte(input logic [W-1:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(empty && !busy && !m_active) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, (n < 3000), 1);
  endtask

  task automatic drain(input int n, input string tag);
    int waited = 0;
    while (got_q.size() < n && waited < 200 * n + 400) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_frame_count"}, (got_q.size() >= n), 1);
    for (int i = 0; i < n; i++) begin
      if (got_q.size() > 0 && exp_q.size() > 0)
        check({tag, "_frame_data"}, got_q.pop_front(), exp_q.pop_front());
    end
  endtask

  task automatic hold_tx();
    hold = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] b;
    int n;

    // 1: reset values
    repeat (3) @(negedge clk);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_tx_send", tx_send, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tx_data", tx_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 2: single byte
    exp_q.push_back(8'hA5);
    write_byte(8'hA5);
    check("single_count1", count, 1);
    check("single_empty0", empty, 0);
    @(negedge clk);
    check("single_count0", count, 0);
    check("single_send", tx_send, 1);
    check("single_data", tx_data, 8'hA5);
    check("single_busy", busy, 1);
    drain(1, "single");
    wait_idle("single");
    check("single_send_low", tx_send, 0);
    check("single_data_kept", tx_data, 8'hA5);

    // 3: burst of 16 into a held transmitter, then drain in order
    hold_tx();
    for (int i = 1; i <= 16; i++) begin
      exp_q.push_back(W'(i));
      write_byte(W'(i));
    end
    check("burst_full", full, 1);
    check("burst_count", count, 16);
    hold = 1'b0;
    drain(16, "burst");
    wait_idle("burst");
    check("burst_empty", empty, 1);

    // 4: overflow with sticky flag and set-wins-over-clear
    hold_tx();
    for (int i = 0; i < 16; i++) begin
      b = W'($urandom_range(0, 255));
      exp_q.push_back(b);
      write_byte(b);
    end
    check("ovf_full", full, 1);
    check("ovf_flag_pre", overflow, 0);
    write_byte(8'hEE);
    check("ovf_flag_set", overflow, 1);
    check("ovf_count", count, 16);
    clr_ovf = 1'b1;
    write_byte(8'hEF);
    clr_ovf = 1'b0;
    check("ovf_set_wins", overflow, 1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);
    hold = 1'b0;
    drain(16, "ovf");
    repeat (200) @(negedge clk);
    check("ovf_no_extra_frame", got_q.size(), 0);
    check("ovf_empty", empty, 1);

    // 5: simultaneous write and pop at count 3
    wait_idle("simul");
    hold_tx();
    for (int i = 0; i < 3; i++) begin
      b = W'($urandom_range(0, 255));
      exp_q.push_back(b);
      write_byte(b);
    end
    check("simul_count_pre", count, 3);
    hold = 1'b0;
    repeat (2) @(negedge clk);
    b = W'($urandom_range(0, 255));
    exp_q.push_back(b);
    write_byte(b);
    check("simul_count_kept", count, 3);
    check("simul_send", tx_send, 1);
    drain(4, "simul");

    // Random bursts with random gaps
    for (int r = 0; r < 6; r++) begin
      wait_idle("rand");
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        b = W'($urandom);
        exp_q.push_back(b);
        write_byte(b);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain(n, "rand");
    end
    wait_idle("rand_end");
    check("frame_overlap", overlap_err, 0);
    check("data_stable", stable_err, 0);

    // 6: reset while the controller waits on an active frame
    exp_q.push_back(8'h11);
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    n = 0;
    while (dbg_state != 2'd2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reach_wait", (n < 500), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_send", tx_send, 0);
    check("midrst_empty", empty, 1);
    check("midrst_count", count, 0);
    check("midrst_busy", busy, 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    got_q.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(8'h3C);
    write_byte(8'h3C);
    drain(1, "post_rst");
    wait_idle("post_rst");
    check("post_rst_queue_empty", got_q.size(), 0);
    check("final_overlap", overlap_err, 0);
    check("final_stable", stable_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
